// File: rtl/note_recorder.sv
// note_recorder: records live key lines as run-length note entries and replays them as key drive.
// Optional NOTE_REC_LOOP_EN: playback wraps to entry 0 and a play pulse during playback stops it.
module note_recorder #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [6:0]                     keys_in,
  input  logic                           rec,
  input  logic                           play,
  output logic [6:0]                     keys_out,
  output logic                           busy,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [6:0]                     seg
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned ENT_W = 3 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};
`ifdef NOTE_REC_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_e;

  function automatic logic [2:0] enc_key(input logic [6:0] k);
    enc_key = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (k[i]) enc_key = 3'(i + 1);
    end
  endfunction

  function automatic logic [6:0] one_hot(input logic [2:0] n);
    one_hot = (n == 3'd0) ? 7'd0 : (7'd1 << (n - 3'd1));
  endfunction

  function automatic logic [6:0] seg7(input logic [2:0] n);
    case (n)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               rec_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         cur_q, cur_d;
  logic               cur_valid_q, cur_valid_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]   ticks_q, ticks_d;
  logic [6:0]         keys_out_q, keys_out_d;
  logic               busy_q;
  logic [6:0]         seg_q, seg_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic               mem_we;

  logic               tick, rec_rise, rec_fall, last;
  logic [DIV_W-1:0]   div_nxt;
  logic [2:0]         key_code, disp;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   rd_idx;
  logic [ENT_W-1:0]   cur_entry, nxt_entry, first_entry;

  assign tick        = (div_q == DIV_W'(TICK_DIV - 1));
  assign div_nxt     = tick ? '0 : div_q + DIV_W'(1);
  assign rec_rise    = rec & ~rec_q;
  assign rec_fall    = ~rec & rec_q;
  assign key_code    = enc_key(keys_in);
  assign cnt_inc     = count_q + CNT_W'(1);
  assign last        = ((CNT_W'(idx_q) + CNT_W'(1)) == count_q);
  assign rd_idx      = last ? '0 : idx_q + IDX_W'(1);
  assign cur_entry   = mem_q[idx_q];
  assign nxt_entry   = mem_q[rd_idx];
  assign first_entry = mem_q[0];

  // Next-state, memory write and registered-output logic.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    dur_d       = dur_q;
    count_d     = count_q;
    full_d      = full_q;
    idx_d       = idx_q;
    ticks_d     = ticks_q;
    keys_out_d  = keys_out_q;
    mem_we      = 1'b0;
    disp        = 3'd0;

    unique case (state_q)
      S_IDLE: begin
        keys_out_d = '0;
        if (rec_rise) begin
          state_d     = S_REC;
          count_d     = '0;
          full_d      = 1'b0;
          div_d       = '0;
          cur_valid_d = 1'b0;
        end else if (play && (count_q != '0)) begin
          state_d    = S_PLAY;
          idx_d      = '0;
          div_d      = '0;
          ticks_d    = '0;
          keys_out_d = one_hot(first_entry[ENT_W-1 -: 3]);
        end
      end

      S_REC: begin
        div_d = div_nxt;
        if (rec_fall) begin
          state_d     = S_IDLE;
          cur_valid_d = 1'b0;
          if (cur_valid_q) begin
            mem_we  = 1'b1;
            count_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEPTH)) full_d = 1'b1;
          end
        end else if (tick) begin
          if (!cur_valid_q) begin
            cur_d       = key_code;
            dur_d       = DUR_W'(1);
            cur_valid_d = 1'b1;
          end else if ((key_code == cur_q) && (dur_q != DUR_MAX)) begin
            dur_d = dur_q + DUR_W'(1);
          end else begin
            // Close the run; the note that would start here is dropped when the memory fills.
            mem_we  = 1'b1;
            count_d = cnt_inc;
            cur_d   = key_code;
            dur_d   = DUR_W'(1);
            if (cnt_inc == CNT_W'(DEPTH)) begin
              full_d      = 1'b1;
              state_d     = S_IDLE;
              cur_valid_d = 1'b0;
            end
          end
        end
      end

      S_PLAY: begin
        div_d = div_nxt;
        if (LOOP_EN && play) begin
          state_d    = S_IDLE;
          keys_out_d = '0;
        end else if (tick) begin
          if ((ticks_q + DUR_W'(1)) == cur_entry[DUR_W-1:0]) begin
            ticks_d = '0;
            if (last && !LOOP_EN) begin
              state_d    = S_IDLE;
              keys_out_d = '0;
            end else begin
              idx_d      = rd_idx;
              keys_out_d = one_hot(nxt_entry[ENT_W-1 -: 3]);
            end
          end else begin
            ticks_d = ticks_q + DUR_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_REC) && cur_valid_d) disp = cur_d;
    else if (state_d == S_PLAY)            disp = enc_key(keys_out_d);
    seg_d = seg7(disp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rec_q       <= 1'b0;
      div_q       <= '0;
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      dur_q       <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      idx_q       <= '0;
      ticks_q     <= '0;
      keys_out_q  <= '0;
      busy_q      <= 1'b0;
      seg_q       <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      rec_q       <= rec;
      div_q       <= div_d;
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      dur_q       <= dur_d;
      count_q     <= count_d;
      full_q      <= full_d;
      idx_q       <= idx_d;
      ticks_q     <= ticks_d;
      keys_out_q  <= keys_out_d;
      busy_q      <= (state_d != S_IDLE);
      seg_q       <= seg_d;
    end
  end

  // Note memory keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[count_q[IDX_W-1:0]] <= {cur_q, dur_q};
  end

  assign keys_out = keys_out_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign count    = count_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: directed and random record/playback sessions.
module tb_note_recorder;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned DUR_W    = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int DUR_MAX = (1 << DUR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       keys_in;
  logic             rec;
  logic             play;
  logic [6:0]       keys_out;
  logic             busy;
  logic             full;
  logic [CNT_W-1:0] count;
  logic [6:0]       seg;

  always #5 clk = ~clk;

  note_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .rec(rec), .play(play),
    .keys_out(keys_out), .busy(busy), .full(full), .count(count), .seg(seg)
  );

  typedef struct { int note; int dur; } ent_t;

  int          total = 0;
  int          bad   = 0;
  logic [14:0] sb [$];
  ent_t        stored [$];
  int          exp_count = 0;
  bit          exp_full  = 1'b0;
  bit          busy_prev = 1'b0;

  function automatic int enc(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [6:0] onehot(input int code);
    return (code == 0) ? 7'd0 : 7'(1 << (code - 1));
  endfunction

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT is (or just was) busy, compare against the next expected item.
  always @(negedge clk) begin
    logic [14:0] e;
    if (busy === 1'b1 || busy_prev) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: busy=%b keys=%b seg=%b with nothing expected", busy, keys_out, seg);
      end else begin
        e = sb.pop_front();
        total++;
        if ({busy, keys_out, seg} !== e) begin
          bad++;
          $display("FAIL stream: got busy=%b keys=%b seg=%b want busy=%b keys=%b seg=%b",
                   busy, keys_out, seg, e[14], e[13:7], e[6:0]);
        end
      end
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic wait_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected outputs never seen", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Model: runs of equal codes, each split into chunks of at most DUR_MAX ticks.
  task automatic rec_session(input logic [6:0] pats [$], input bit sim_play);
    int   n;
    int   codes [$];
    ent_t all [$];
    int   i, run, rem, acc, stop_tick, nstore, reps;
    n = pats.size();
    foreach (pats[k]) codes.push_back(enc(pats[k]));
    i = 0;
    while (i < n) begin
      run = 1;
      while (i + run < n && codes[i + run] == codes[i]) run++;
      rem = run;
      while (rem > 0) begin
        ent_t e;
        e.note = codes[i];
        e.dur  = (rem > DUR_MAX) ? DUR_MAX : rem;
        all.push_back(e);
        rem -= e.dur;
      end
      i += run;
    end
    stop_tick = 0;
    if (all.size() > DEPTH) begin
      acc = 0;
      for (int k = 0; k < DEPTH; k++) acc += all[k].dur;
      stop_tick = acc + 1;
    end
    nstore = (all.size() > DEPTH) ? DEPTH : all.size();
    stored.delete();
    for (int k = 0; k < nstore; k++) stored.push_back(all[k]);
    exp_count = nstore;
    exp_full  = (all.size() >= DEPTH);

    repeat (TICK_DIV) sb.push_back({1'b1, 7'd0, seg_of(0)});
    for (int k = 1; k <= n; k++) begin
      if (k == stop_tick) break;
      reps = (k == n) ? 1 : TICK_DIV;
      repeat (reps) sb.push_back({1'b1, 7'd0, seg_of(codes[k - 1])});
    end
    sb.push_back({1'b0, 7'd0, seg_of(0)});

    @(negedge clk);
    rec = 1'b1; play = sim_play; keys_in = pats[0];
    @(negedge clk);
    play = 1'b0;
    for (int k = 0; k < n; k++) begin
      keys_in = pats[k];
      play = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      play = 1'b0;
      repeat (TICK_DIV - 1) @(negedge clk);
    end
    rec = 1'b0;
    wait_drain();
    check("count", 32'(count), 32'(exp_count));
    check("full", 32'(full), 32'(exp_full));
  endtask

  task automatic push_pass(output int cycles);
    cycles = 0;
    foreach (stored[k]) begin
      repeat (stored[k].dur * TICK_DIV)
        sb.push_back({1'b1, onehot(stored[k].note), seg_of(stored[k].note)});
      cycles += stored[k].dur * TICK_DIV;
    end
  endtask

  task automatic play_session();
    int t;
    t = 0;
    if (exp_count > 0) begin
      push_pass(t);
`ifdef NOTE_REC_LOOP_EN
      push_pass(t);
`endif
      sb.push_back({1'b0, 7'd0, seg_of(0)});
    end
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
`ifdef NOTE_REC_LOOP_EN
    if (exp_count > 0) begin
      repeat (2 * t - 1) @(negedge clk);
      play = 1'b1;
      @(negedge clk); play = 1'b0;
    end
`endif
    if (exp_count == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("ignored_play_busy", 32'(busy), 32'(0));
      end
    end
    wait_drain();
  endtask

  task automatic reset_mid_play();
    repeat (3) sb.push_back({1'b1, onehot(stored[0].note), seg_of(stored[0].note)});
    sb.push_back({1'b0, 7'd0, seg_of(0)});
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_keys_out", 32'(keys_out), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    exp_count = 0;
    exp_full  = 1'b0;
    wait_drain();
  endtask

  initial begin
    logic [6:0] q [$];
    logic [6:0] p;
    int         n;
    rst = 1'b1; rec = 1'b0; play = 1'b0; keys_in = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_keys_out", 32'(keys_out), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_full", 32'(full), 32'(0));
    check("reset_count", 32'(count), 32'(0));
    check("reset_seg", 32'(seg), 32'(7'b1000000));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    q = '{7'h01, 7'h01, 7'h01, 7'h02, 7'h02};
    rec_session(q, 1'b0);
    play_session();

    q = '{7'b1000001, 7'b1000001};
    rec_session(q, 1'b1);
    play_session();

    q = '{7'h04, 7'h04, 7'h04, 7'h04, 7'h04};
    rec_session(q, 1'b0);
    play_session();
    play_session();

    q = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};
    rec_session(q, 1'b0);
    play_session();

    reset_mid_play();
    play_session();

    for (int s = 0; s < 20; s++) begin
      q.delete();
      n = $urandom_range(1, 9);
      p = 7'($urandom);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0, 1: p = p;
          2:    p = 7'($urandom);
          default: p = 7'd0;
        endcase
        q.push_back(p);
      end
      rec_session(q, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) != 0) play_session();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
